ahb_slave: RTL and testbench

- AHB-Lite subordinate: the configuration/status port of the AES accelerator, the other end of the bus from the DMA master.
- The host CPU uses it to program source address, destination address, transfer size, key and mode, then launch the accelerator and poll or get an interrupt on completion.
- It converts bus accesses into a register file, presents static configuration plus a start pulse to the core, and gathers done/error status from it.

---
 rtl/ahb_slave.sv | 146 ++++++++++++++
 tb/tb_ahb_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave.sv
// AHB-Lite config/status port of the AES accelerator: register file, start pulse, done/err status and irq.
// Legal accesses take zero wait states. Illegal ones get a two-cycle ERROR response and leave every register unchanged.
module ahb_slave #(
  parameter int ADDR_BITS = 6,
  parameter int KEY_WORDS = 4
) (
  input  logic                    hclk,
  input  logic                    hrst,
  input  logic                    hsel,
  input  logic [31:0]             haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [31:0]             hwdata,
  input  logic                    hready,
  output logic [31:0]             hrdata,
  output logic                    hreadyout,
  output logic                    hresp,
  input  logic                    core_busy,
  input  logic                    core_done,
  input  logic                    core_err,
  output logic                    start,
  output logic                    mode,
  output logic [31:0]             src_addr,
  output logic [31:0]             dst_addr,
  output logic [31:0]             size,
  output logic [32*KEY_WORDS-1:0] key,
  output logic                    irq
);

  localparam int IW = ADDR_BITS - 2;
  localparam logic [IW-1:0] IDX_CTRL   = IW'(0);
  localparam logic [IW-1:0] IDX_STATUS = IW'(1);
  localparam logic [IW-1:0] IDX_SRC    = IW'(2);
  localparam logic [IW-1:0] IDX_DST    = IW'(3);
  localparam logic [IW-1:0] IDX_SIZE   = IW'(4);
  localparam logic [IW-1:0] IDX_LAST   = IW'(4 + KEY_WORDS);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          write;
  } cap_t;

  state_t        state, state_nxt;
  cap_t          cap;
  logic [IW-1:0] a_idx;
  logic          accept, a_legal;
  logic          start_err, wr_en, wr_status;
  logic          irq_en, done_flag, err_flag;
  logic          unused_ok;

  assign unused_ok = ^{haddr[31:ADDR_BITS], htrans[0]};

  // Address-phase decode: mapping, size and busy lockout are all known here.
  assign a_idx   = haddr[ADDR_BITS-1:2];
  assign a_legal = (haddr[1:0] == 2'b00) && (a_idx <= IDX_LAST) && (hsize == 3'b010)
                   && !(hwrite && core_busy && (a_idx != IDX_STATUS));
  assign accept  = hsel & hready & htrans[1] & hreadyout;

  // START with a zero block count is only visible once hwdata arrives, so the
  // data phase itself becomes the first ERROR cycle.
  assign start_err = (state == DATA) && cap.write && (cap.idx == IDX_CTRL)
                     && hwdata[0] && (size == 32'd0);
  assign wr_en     = (state == DATA) && cap.write && !start_err;
  assign wr_status = wr_en && (cap.idx == IDX_STATUS);

  assign hreadyout = !((state == ERR1) || start_err);
  assign hresp     = (state == ERR1) || (state == ERR2) || start_err;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cap <= '{idx: a_idx, write: hwrite};
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if ((state == ERR1) || start_err) begin
      state_nxt = ERR2;
    end else if (accept) begin
      state_nxt = a_legal ? DATA : ERR1;
    end
  end

  always_comb begin
    hrdata = '0;
    if (state == DATA) begin
      case (cap.idx)
        IDX_CTRL:   hrdata = {29'd0, irq_en, mode, 1'b0};
        IDX_STATUS: hrdata = {29'd0, err_flag, done_flag, core_busy};
        IDX_SRC:    hrdata = src_addr;
        IDX_DST:    hrdata = dst_addr;
        IDX_SIZE:   hrdata = size;
        default: begin
          for (int i = 0; i < KEY_WORDS; i++) begin
            if (cap.idx == IW'(5 + i)) hrdata = key[32*i +: 32];
          end
        end
      endcase
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      start     <= 1'b0;
      mode      <= 1'b0;
      irq_en    <= 1'b0;
      src_addr  <= '0;
      dst_addr  <= '0;
      size      <= '0;
      key       <= '0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      start <= wr_en && (cap.idx == IDX_CTRL) && hwdata[0];
      irq   <= irq_en & (done_flag | err_flag);
      // A status event in the same cycle as its W1C clear must not be lost.
      done_flag <= core_done | (done_flag & !(wr_status & hwdata[1]));
      err_flag  <= core_err  | (err_flag  & !(wr_status & hwdata[2]));
      if (wr_en) begin
        case (cap.idx)
          IDX_CTRL: begin
            mode   <= hwdata[1];
            irq_en <= hwdata[2];
          end
          IDX_SRC:  src_addr <= hwdata;
          IDX_DST:  dst_addr <= hwdata;
          IDX_SIZE: size     <= hwdata;
          default: begin
            for (int i = 0; i < KEY_WORDS; i++) begin
              if (cap.idx == IW'(5 + i)) key[32*i +: 32] <= hwdata;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave.sv
// Directed self-checking bench for ahb_slave: register map, start pulse, error responses, W1C status, irq, async reset.
module tb_ahb_slave;
  logic         hclk = 1'b0;
  logic         hrst;
  logic         hsel;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [31:0]  hwdata;
  logic         hready;
  logic [31:0]  hrdata;
  logic         hreadyout;
  logic         hresp;
  logic         core_busy, core_done, core_err;
  logic         start, mode, irq;
  logic [31:0]  src_addr, dst_addr, size;
  logic [127:0] key;

  int n_tests   = 0;
  int n_fail    = 0;
  int start_cnt = 0;

  // Single-slave bus: the interconnect's hready is this slave's hreadyout.
  assign hready = hreadyout;

  ahb_slave #(.ADDR_BITS(6), .KEY_WORDS(4)) dut (
    .hclk(hclk), .hrst(hrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
    .start(start), .mode(mode), .src_addr(src_addr), .dst_addr(dst_addr),
    .size(size), .key(key), .irq(irq)
  );

  always #5 hclk = ~hclk;

  always @(negedge hclk) if (start) start_cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One non-overlapped transfer; called and returns at posedge+1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wdata, input logic pulse_done,
                      output logic [31:0] rdata, output int waits, output logic [1:0] resp);
    bit ended = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata; core_done = pulse_done;
    waits = 0; resp = 2'b00; rdata = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge hclk);
      rdata = hrdata;
      if (i == 0) resp[1] = hresp;
      resp[0] = hresp;
      if (hreadyout) begin
        ended = 1'b1;
        break;
      end
      waits++;
      @(posedge hclk); #1;
      core_done = 1'b0;
    end
    if (!ended) chk("xfer_timeout", 1'b0, 1'b1);
    @(posedge hclk); #1;
    core_done = 1'b0;
  endtask

  task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data, input logic pulse_done);
    logic [31:0] rd;
    int          w;
    logic [1:0]  r;
    xfer(1'b1, addr, 3'b010, data, pulse_done, rd, w, r);
    chk($sformatf("wr_resp_%0h", addr), {r, 8'(w)}, 10'd0);
  endtask

  task automatic rd_ok(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    int          w;
    logic [1:0]  r;
    xfer(1'b0, addr, 3'b010, 32'd0, 1'b0, rd, w, r);
    chk($sformatf("%s_%0h", tag, addr), rd, exp);
    chk($sformatf("%s_resp_%0h", tag, addr), {r, 8'(w)}, 10'd0);
  endtask

  task automatic xfer_err(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                          input logic [31:0] data, input string tag);
    logic [31:0] rd;
    int          w;
    logic [1:0]  r;
    xfer(wr, addr, sz, data, 1'b0, rd, w, r);
    chk(tag, {r, 8'(w)}, {2'b11, 8'd1});
  endtask

  initial begin
    hrst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; core_busy = 1'b0; core_done = 1'b0; core_err = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_ctl", {hreadyout, hresp, start, irq, mode}, 5'b10000);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_cfg", {src_addr, dst_addr, size}, 96'd0);
    chk("rst_key", key, 128'd0);
    hrst = 1'b0;
    @(posedge hclk); #1;

    for (int a = 0; a <= 32; a += 4) rd_ok(a, 32'd0, "rd_rst");

    wr_ok(32'h08, 32'h1000, 1'b0);
    wr_ok(32'h0C, 32'h2000, 1'b0);
    wr_ok(32'h10, 32'd4, 1'b0);
    for (int i = 0; i < 4; i++) wr_ok(32'h14 + 4*i, 32'hA5A5_0000 + i, 1'b0);
    wr_ok(32'h00, 32'h6, 1'b0);
    rd_ok(32'h08, 32'h1000, "rd_src");
    rd_ok(32'h0C, 32'h2000, "rd_dst");
    rd_ok(32'h10, 32'd4, "rd_size");
    for (int i = 0; i < 4; i++) rd_ok(32'h14 + 4*i, 32'hA5A5_0000 + i, "rd_key");
    rd_ok(32'h00, 32'h6, "rd_ctrl");
    chk("cfg_ports", {src_addr, dst_addr, size, mode}, {32'h1000, 32'h2000, 32'd4, 1'b1});
    chk("key_port", key, {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000});
    chk("no_start", start_cnt, 0);

    // Launch with MODE/IRQ_EN kept set.
    wr_ok(32'h00, 32'h7, 1'b0);
    chk("start_hi", start, 1'b1);
    @(posedge hclk); #1;
    chk("start_lo", start, 1'b0);
    chk("start_cnt1", start_cnt, 1);
    rd_ok(32'h00, 32'h6, "rd_ctrl_after_start");

    core_busy = 1'b1;
    xfer_err(1'b1, 32'h08, 3'b010, 32'hDEAD, "err_busy_wr");
    rd_ok(32'h04, 32'h1, "rd_status_busy");
    rd_ok(32'h08, 32'h1000, "rd_src_kept");
    core_busy = 1'b0;

    core_done = 1'b1;
    @(posedge hclk); #1;
    core_done = 1'b0;
    chk("irq_lag", irq, 1'b0);
    @(posedge hclk); #1;
    chk("irq_set", irq, 1'b1);
    rd_ok(32'h04, 32'h2, "rd_status_done");
    wr_ok(32'h04, 32'h2, 1'b0);
    @(posedge hclk); #1;
    chk("irq_clr", irq, 1'b0);
    rd_ok(32'h04, 32'h0, "rd_status_clr");
    wr_ok(32'h04, 32'h2, 1'b1);
    rd_ok(32'h04, 32'h2, "rd_status_setwins");
    core_err = 1'b1;
    @(posedge hclk); #1;
    core_err = 1'b0;
    rd_ok(32'h04, 32'h6, "rd_status_err");
    wr_ok(32'h04, 32'h6, 1'b0);
    rd_ok(32'h04, 32'h0, "rd_status_clr2");

    xfer_err(1'b0, 32'h3C, 3'b010, 32'd0, "err_unmapped");
    xfer_err(1'b0, 32'h08, 3'b001, 32'd0, "err_halfword");
    rd_ok(32'h08, 32'h1000, "rd_src_after_err");

    // Pipelined write then read of the same register.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hwdata = 32'h1234_5678; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("b2b_rd", hrdata, 32'h1234_5678);
    chk("b2b_resp", {hreadyout, hresp}, 2'b10);
    @(posedge hclk); #1;
    chk("b2b_key0", key[31:0], 32'h1234_5678);

    wr_ok(32'h10, 32'd0, 1'b0);
    xfer_err(1'b1, 32'h00, 3'b010, 32'h1, "err_start_size0");
    @(posedge hclk); #1;
    chk("no_start_size0", start_cnt, 1);
    rd_ok(32'h00, 32'h6, "rd_ctrl_kept");

    // Asynchronous reset in the middle of a read data phase.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    chk("pre_rst_rd", hrdata, 32'h1000);
    hrst = 1'b1;
    #1;
    chk("arst_ctl", {hreadyout, hresp, start, irq, mode}, 5'b10000);
    chk("arst_hrdata", hrdata, 32'd0);
    chk("arst_cfg", {src_addr, dst_addr, size}, 96'd0);
    chk("arst_key", key, 128'd0);
    repeat (2) @(posedge hclk);
    hrst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
